mux_8to1_rr: RTL

// - Merges eight valid/ready input streams into one registered output stream.
// - Uses round-robin arbitration and tags each beat with its source index on sel2..sel0.
// - The tag uses the same encoding as the dmux_1to8 selects, so a downstream dmux_1to8 can route replies back.
// - Sits between per-channel producers and a shared datapath.

---
 rtl/mux_8to1_rr.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mux_8to1_rr.sv
// mux_8to1_rr: eight valid/ready input streams merged into one registered
// output stream by a round-robin arbiter. Each output beat carries its source
// channel index on {sel2,sel1,sel0}, encoded like the dmux_1to8 selects.
// Optional packet lock: define MUX_PKT_LOCK_EN to add in_last/out_last and
// hold the grant on one channel until that channel's last beat is accepted.
module mux_8to1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*WIDTH-1:0] in_data,
  input  logic [7:0]         in_valid,
  output logic [7:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel0,
  output logic               sel1,
  output logic               sel2
`ifdef MUX_PKT_LOCK_EN
  ,
  input  logic [7:0]         in_last,
  output logic               out_last
`endif
);

  // Round-robin pick: first requester strictly after ptr, wrapping upward.
  // With no requester the result is don't-care and is returned as 0.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_pick = 3'd0;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + k[2:0];
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  logic [2:0]       r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [2:0]       r_sel;

  logic             w_load;
  logic [2:0]       w_rr_grant;
  logic [2:0]       w_grant;
  logic             w_req_any;
  logic             w_accept;
  logic [7:0]       w_in_ready;

`ifdef MUX_PKT_LOCK_EN
  logic             r_locked;
  logic [2:0]       r_lock_ch;
  logic             r_out_last;
`endif

  // Output stage may take a new beat when empty or when its beat drains now.
  assign w_load     = !r_out_valid | out_ready;
  assign w_rr_grant = rr_pick(in_valid, r_ptr);

  // Grant selection; a locked packet overrides the round-robin choice.
  always_comb begin
    w_grant   = w_rr_grant;
    w_req_any = |in_valid;
`ifdef MUX_PKT_LOCK_EN
    if (r_locked) begin
      w_grant   = r_lock_ch;
      w_req_any = in_valid[r_lock_ch];
    end else begin
      w_grant   = w_rr_grant;
      w_req_any = |in_valid;
    end
`endif
  end

  // One-hot ready towards the single granted channel, only when accepting.
  always_comb begin
    w_accept   = w_load & w_req_any;
    w_in_ready = 8'd0;
    if (w_accept) begin
      w_in_ready = 8'd1 << w_grant;
    end else begin
      w_in_ready = 8'd0;
    end
  end

  // Output register, priority pointer and sel tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= 3'd7;
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_sel       <= 3'd0;
    end else if (w_accept) begin
      r_out_data  <= in_data[w_grant*WIDTH +: WIDTH];
      r_sel       <= w_grant;
      r_out_valid <= 1'b1;
      r_ptr       <= w_grant;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

`ifdef MUX_PKT_LOCK_EN
  // Packet lock tracking and registered last flag of the winning beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked   <= 1'b0;
      r_lock_ch  <= 3'd0;
      r_out_last <= 1'b0;
    end else if (w_accept) begin
      r_out_last <= in_last[w_grant];
      r_lock_ch  <= w_grant;
      r_locked   <= !in_last[w_grant];
    end else begin
      r_locked   <= r_locked;
    end
  end

  assign out_last = r_out_last;
`endif

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign sel0      = r_sel[0];
  assign sel1      = r_sel[1];
  assign sel2      = r_sel[2];

endmodule
